uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
// PURPOSE
//   Fabric UART receiver with a receive FIFO. It sits downstream of the MSS UART TX pin in the
//   UART_INT1 system and deserialises 8N1 frames using 16x oversampling.
//   Received bytes are queued in a first-word-fall-through FIFO. A fabric consumer reads them
//   through a valid/ready handshake. Framing errors and overruns are reported to that consumer.
// PARAMETERS
//   BAUD_DIV    27  FAB_CCC_GL0 cycles per oversample tick (50 MHz / (115200*16)); must be >= 2
//   FIFO_DEPTH  8   receive FIFO entries; power of two, >= 2
// PORTS
//   FAB_CCC_GL0  in   1   clock; the only clock, all logic on its rising edge
//   FAB_RESET_N  in   1   reset; synchronous, active-low
//   RX_SERIAL    in   1   asynchronous serial input; idle high; connects to MSS UART TX
//   RDATA        out  8   FIFO head byte; valid only while RVALID=1
//   RVALID       out  1   FIFO not empty
//   RREADY       in   1   consumer accept; a pop occurs when RVALID & RREADY
//   FIFO_COUNT   out  clog2(FIFO_DEPTH+1)  number of bytes currently held
//   FRAME_ERR    out  1   one-cycle pulse when a stop bit is sampled low
//   OVERRUN      out  1   sticky; set when a good byte arrives while the FIFO is full
//   CLR_ERR      in   1   clears OVERRUN; if set and clear occur in the same cycle, set wins
// BEHAVIOUR
//   Reset (FAB_RESET_N=0 at a clock edge)
//     - RDATA=0, RVALID=0, FIFO_COUNT=0, FRAME_ERR=0, OVERRUN=0.
//     - Synchroniser flops reset to 1. FSM returns to IDLE. Tick counter is cleared.
//     - Reset mid-frame discards the partial byte.
//   Input synchroniser
//     - 2-flop synchroniser on RX_SERIAL, giving rx_s.
//   Tick counter
//     - Counts 0..BAUD_DIV-1; tick=1 in the cycle the count equals BAUD_DIV-1.
//     - Counter is reloaded to 0 when a start edge is detected, so sampling aligns to the edge.
//   FSM states: IDLE, START, DATA, STOP, WAIT_IDLE
//     - IDLE: falling edge of rx_s (previous 1, current 0) -> START; clear the sample counter.
//     - START: on the 8th tick, sample rx_s.
//         rx_s=0 -> DATA with bit index 0.
//         rx_s=1 -> glitch: back to IDLE, nothing pushed.
//     - DATA: every 16th tick, shift rx_s into a shift register, LSB first.
//         After bit 7 -> STOP.
//     - STOP: on the 16th tick, sample rx_s.
//         rx_s=1 -> push the byte -> IDLE.
//         rx_s=0 -> FRAME_ERR pulse for 1 cycle, byte discarded -> WAIT_IDLE.
//     - WAIT_IDLE: stay until rx_s=1 (covers a break condition) -> IDLE.
//   FIFO
//     - First-word fall-through: RDATA and RVALID reflect the head with no read latency.
//     - Latency: a pushed byte is visible on RVALID/RDATA in the cycle after the stop-sample tick.
//     - Push when empty updates RVALID on that next edge.
//     - Full:
//         push alone -> byte dropped, OVERRUN set.
//         push and pop in the same cycle -> both happen, COUNT unchanged, no overrun.
//     - Empty: RREADY is ignored and there is no underflow.
//     - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally. COUNT saturates at FIFO_DEPTH.
// STRUCTURE
//   Shared package uart_pkg (also used by the future TX block):
//     - rx_state_t enum.
//     - OVERSAMPLE=16, MID_SAMPLE=8, DATA_BITS=8.
//   One sub-module, uart_sync_fifo (WIDTH, DEPTH):
//     - Ports: push, wdata, pop, rdata, empty, full, count.
//   Top level contains the synchroniser, tick counter, FSM, shifter and error flags.
// TESTING (sim with BAUD_DIV=4, so 64 clocks per bit)
//   1. Send frame 0xA5 with a good stop bit
//      -> RVALID=1, RDATA=0xA5, FIFO_COUNT=1 one cycle after the stop sample.
//      -> Pulse RREADY -> RVALID=0.
//   2. Drive RX_SERIAL low for 5 ticks, then high (glitch)
//      -> FSM back in IDLE, FIFO_COUNT=0, FRAME_ERR stays 0.
//   3. Send frame 0x3C with stop bit 0, holding the line low for 2 bit times
//      -> FRAME_ERR high for exactly 1 cycle, no push.
//      -> A following good 0x11 is received correctly.
//   4. Send 9 back-to-back frames 0x01..0x09 with RREADY=0
//      -> FIFO_COUNT=8, OVERRUN=1.
//      -> Reads return 0x01..0x08 in order. CLR_ERR -> OVERRUN=0.
//   5. FIFO full, RREADY=1 in the same cycle as the push of 0x5A
//      -> FIFO_COUNT stays 8, OVERRUN stays 0, 0x5A is the last byte read.
//   6. Assert FAB_RESET_N=0 for 1 cycle mid-DATA
//      -> all outputs read their reset values on the next edge.
//      -> The next full frame 0x77 is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions. The receiver uses them today and the transmitter will reuse them.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always presented on rdata_o.
// rdata_o reads as zero while the FIFO is empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot that a push in the same cycle needs when the FIFO is full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with 16x oversampling that feeds a FWFT receive FIFO.
// A consumer drains the FIFO through RDATA/RVALID/RREADY.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            FAB_CCC_GL0,
  input  logic                            FAB_RESET_N,
  input  logic                            RX_SERIAL,
  output logic [7:0]                      RDATA,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT,
  output logic                            FRAME_ERR,
  output logic                            OVERRUN,
  input  logic                            CLR_ERR,
  output rx_state_t                       dbg_state_o
);

  localparam int TW = $clog2(BAUD_DIV);

  logic                 sync1_q, sync2_q, rx_prev_q;
  logic                 rx_s, start_edge, tick;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  rx_state_t            state_q;
  logic [3:0]           samp_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;
  logic                 overrun_q, overrun_d;
  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;

  assign rx_s       = sync2_q;
  assign start_edge = rx_prev_q & ~rx_s;
  assign tick       = (tick_cnt_q == TW'(BAUD_DIV - 1));

  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= RX_SERIAL;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // The start edge restarts the oversample phase so that ticks line up with the bit boundaries.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    if (state_q == RX_IDLE && start_edge) tick_cnt_d = '0;
  end

  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) tick_cnt_q <= '0;
    else              tick_cnt_q <= tick_cnt_d;
  end

  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      state_q     <= RX_IDLE;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (start_edge) begin
            state_q    <= RX_START;
            samp_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (samp_cnt_q == 4'(MID_SAMPLE - 1)) begin
              samp_cnt_q <= '0;
              bit_idx_q  <= '0;
              state_q    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              samp_cnt_q <= samp_cnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (samp_cnt_q == 4'(OVERSAMPLE - 1)) begin
              samp_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_idx_q  <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= RX_STOP;
            end else begin
              samp_cnt_q <= samp_cnt_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (samp_cnt_q == 4'(OVERSAMPLE - 1)) begin
              samp_cnt_q <= '0;
              if (rx_s) begin
                state_q <= RX_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= RX_WAIT_IDLE;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 4'd1;
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_s) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // The push is decoded from the stop-sample cycle so the byte is at the FIFO head one cycle later.
  assign fifo_push = (state_q == RX_STOP) && tick &&
                     (samp_cnt_q == 4'(OVERSAMPLE - 1)) && rx_s;

  // Handshake: a byte transfers on every rising edge where RVALID and RREADY are both high.
  // RVALID never depends on RREADY, and RDATA holds steady until that byte is accepted.
  assign fifo_pop  = RVALID & RREADY;
  assign overrun_d = (fifo_push & fifo_full & ~fifo_pop) | (overrun_q & ~CLR_ERR);

  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) overrun_q <= 1'b0;
    else              overrun_q <= overrun_d;
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (FAB_CCC_GL0),
    .rst_ni  (FAB_RESET_N),
    .push_i  (fifo_push),
    .wdata_i (shift_q),
    .pop_i   (RREADY),
    .rdata_o (RDATA),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (FIFO_COUNT)
  );

  assign RVALID      = ~fifo_empty;
  assign FRAME_ERR   = frame_err_q;
  assign OVERRUN     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer. It drives serial frames, and a byte queue models the FIFO contents,
// which are checked on every accepted read.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int B        = 4;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 16 * B;
  localparam int PUSH_OFS = 2 + (8 + 16 * 9) * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, frame_err, overrun;
  logic [3:0] fifo_count;
  rx_state_t  dbg_state;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         fe_cnt = 0;

  uart_rx_buffer #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET_N (rst_n),
    .RX_SERIAL   (rx),
    .RDATA       (rdata),
    .RVALID      (rvalid),
    .RREADY      (rready),
    .FIFO_COUNT  (fifo_count),
    .FRAME_ERR   (frame_err),
    .OVERRUN     (overrun),
    .CLR_ERR     (clr_err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first n_bits of {stop, data, start}, starting with the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int n_bits);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < n_bits; i++) begin
      rx = f[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic model_good_byte(input logic [7:0] d, inout logic ovr);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else ovr = 1'b1;
  endtask

  task automatic read_one();
    check("rvalid_before_read", rvalid, 1'b1);
    rready = 1'b1;
    wait_clks(1);
    rready = 1'b0;
  endtask

  // Scoreboard: each accepted read must match the oldest byte the model holds.
  always @(negedge clk) begin
    logic [7:0] e;
    if (frame_err) fe_cnt++;
    if (rst_n && rvalid && rready) begin
      check("pop_has_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
      end
    end
  end

  initial begin
    int   fe0, n_bad, bound;
    logic ovr;
    logic [7:0] d;
    logic good;
    bit   rand_done;

    wait_clks(3);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_count", fifo_count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);

    // 1: single good frame and its push latency
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 10);
      begin
        wait_clks(PUSH_OFS);
        check("t1_rvalid_at_stop_sample", rvalid, 0);
        wait_clks(1);
        check("t1_rvalid", rvalid, 1);
        check("t1_rdata", rdata, 8'hA5);
        check("t1_count", fifo_count, 1);
      end
    join
    read_one();
    check("t1_rvalid_after_read", rvalid, 0);

    // 2: short low glitch is rejected
    fe0 = fe_cnt;
    rx = 1'b0;
    wait_clks(5 * B);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("t2_state_idle", dbg_state, RX_IDLE);
    check("t2_count", fifo_count, 0);
    check("t2_no_frame_err", fe_cnt - fe0, 0);

    // 3: bad stop bit with line held low, then a good byte
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 10);
    wait_clks(2 * BIT_CLKS);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("t3_frame_err_pulses", fe_cnt - fe0, 1);
    check("t3_count", fifo_count, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 10);
    check("t3_count_after_good", fifo_count, 1);
    read_one();

    // 4: nine back-to-back frames overflow the FIFO
    ovr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      model_good_byte(8'(i), ovr);
      send_frame(8'(i), 1'b1, 10);
    end
    check("t4_count", fifo_count, DEPTH);
    check("t4_overrun", overrun, ovr);
    for (int i = 0; i < DEPTH; i++) read_one();
    check("t4_rvalid_drained", rvalid, 0);
    check("t4_overrun_held", overrun, 1);
    clr_err = 1'b1;
    wait_clks(1);
    clr_err = 1'b0;
    check("t4_overrun_cleared", overrun, 0);

    // 5: push into a full FIFO in the same cycle as a read
    ovr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_good_byte(8'h21 + 8'(i), ovr);
      send_frame(8'h21 + 8'(i), 1'b1, 10);
    end
    check("t5_full_count", fifo_count, DEPTH);
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1, 10);
      begin
        wait_clks(PUSH_OFS);
        rready = 1'b1;
        wait_clks(1);
        rready = 1'b0;
        check("t5_count_same", fifo_count, DEPTH);
        check("t5_no_overrun", overrun, 0);
      end
    join
    for (int i = 0; i < DEPTH; i++) read_one();
    check("t5_queue_drained", exp_q.size(), 0);
    check("t5_rvalid_drained", rvalid, 0);

    // 6: reset pulse in the middle of the data bits
    ovr = 1'b0;
    model_good_byte(8'h42, ovr);
    send_frame(8'h42, 1'b1, 10);
    send_frame(8'h99, 1'b1, 4);
    check("t6_mid_data", dbg_state, RX_DATA);
    rst_n = 1'b0;
    rx = 1'b1;
    wait_clks(1);
    check("t6_rst_rvalid", rvalid, 0);
    check("t6_rst_rdata", rdata, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_state", dbg_state, RX_IDLE);
    rst_n = 1'b1;
    exp_q.delete();
    wait_clks(BIT_CLKS);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 10);
    check("t6_count", fifo_count, 1);
    read_one();

    // Random: frames with random data, stop bits and gaps, drained by a random consumer
    fe0 = fe_cnt;
    n_bad = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          d = 8'($urandom_range(0, 255));
          good = ($urandom_range(0, 4) != 0);
          if (good) exp_q.push_back(d);
          else n_bad++;
          send_frame(d, good, 10);
          rx = 1'b1;
          wait_clks(good ? $urandom_range(1, 40) : BIT_CLKS + $urandom_range(1, 40));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rready = 1'($urandom_range(0, 1));
          wait_clks(1);
        end
        rready = 1'b0;
      end
    join
    bound = 0;
    while (rvalid && bound < 4 * DEPTH) begin
      read_one();
      bound++;
    end
    check("rand_drain_bounded", (bound < 4 * DEPTH), 1'b1);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_frame_errs", fe_cnt - fe0, n_bad);
    check("rand_no_overrun", overrun, 0);
    check("rand_final_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
